// File: rtl/uart_tx_queue.sv
// Byte queue feeding a uart_transmitter: circular buffer plus an IDLE/SEND/BUSY handshake FSM.
// Optional sticky overflow flag is built only when UART_TX_QUEUE_OVERFLOW_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          wr_data,
  input  logic                wr_en,
  input  logic                flush,
  output logic                full,
  output logic                empty,
  output logic [ADDR_WIDTH:0] count,
  output logic                overflow,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_busy,
  output logic [1:0]          dbg_state
);

  // Handshake with the transmitter: tx_send is held high until tx_busy is seen,
  // then the FSM waits for tx_busy to fall before presenting the next byte.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state, state_next;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  push, pop, send_next;

  assign count     = count_r;
  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == '0);
  assign dbg_state = state;

  // A full queue drops the write even if a pop frees a slot on the same edge.
  assign push = wr_en && !full && !flush;
  assign pop  = (state == S_IDLE) && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + (ADDR_WIDTH+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_WIDTH+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data <= 8'h00;
    end else if (pop) begin
      tx_data <= mem[rd_ptr];
    end
  end

  // State register; tx_send is registered from the next state so it is high exactly in S_SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tx_send <= 1'b0;
    end else begin
      state   <= state_next;
      tx_send <= send_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pop)      state_next = S_SEND;
      S_SEND:  if (tx_busy)  state_next = S_BUSY;
      S_BUSY:  if (!tx_busy) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  always_comb begin
    send_next = (state_next == S_SEND);
  end

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic overflow_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r <= 1'b0;
    end else if (wr_en && full) begin
      overflow_r <= 1'b1;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: scoreboard on transmitted bytes plus cycle-exact checks.
module tb_uart_tx_queue;

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       full, empty, overflow, tx_send, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic [1:0] dbg_state;

  logic       busy_force, busy_auto, auto_busy;
  int         busy_delay, busy_hold;
  int         n_checks, n_errors, rise_cnt, rise_before;
  logic       prev_send;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  assign tx_busy = busy_force | busy_auto;

  uart_tx_queue #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // drivers
  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wr_exp(input logic [7:0] d);
    exp_q.push_back(d);
    wr(d);
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while (!(dbg_state == 2'd0 && empty && !tx_busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(n < max), 32'd1);
  endtask

  // transmitter busy model: rises busy_delay edges after tx_send, holds busy_hold cycles
  initial begin
    busy_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_busy && tx_send && !reset) begin
        repeat (busy_delay - 1) @(negedge clk);
        busy_auto = 1'b1;
        repeat (busy_hold) @(negedge clk);
        busy_auto = 1'b0;
      end
    end
  end

  // monitor: each tx_send rising edge pops one expected byte
  initial begin
    prev_send = 1'b0;
    rise_cnt  = 0;
    forever begin
      @(negedge clk);
      if (tx_send && !prev_send) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_byte: got %0h expected no transmission", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(exp_b));
        end
      end
      prev_send = tx_send;
    end
  end

  initial begin
    n_checks = 0; n_errors = 0;
    wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    busy_force = 1'b0; auto_busy = 1'b0; busy_delay = 3; busy_hold = 20;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);

    // single byte with busy rising 3 cycles after tx_send
    auto_busy = 1'b1; busy_delay = 3; busy_hold = 20;
    wr_exp(8'hA5);
    check("lat_count_after_write", 32'(count), 32'd1);
    check("lat_send_edge1", 32'(tx_send), 32'd0);
    @(negedge clk);
    check("lat_send_edge2", 32'(tx_send), 32'd1);
    check("lat_data_edge2", 32'(tx_data), 32'hA5);
    check("lat_empty_after_pop", 32'(empty), 32'd1);
    @(negedge clk);
    check("send_hold_1", 32'(tx_send), 32'd1);
    @(negedge clk);
    check("send_hold_2", 32'(tx_send), 32'd1);
    @(negedge clk);
    check("send_fall_on_busy", 32'(tx_send), 32'd0);
    check("state_busy", 32'(dbg_state), 32'd2);
    wait_idle(200, "idle_after_a5");

    // fill with busy held high, then overflow and write+pop while full
    auto_busy = 1'b0; busy_force = 1'b1; busy_hold = 2;
    for (int i = 0; i < 16; i++) wr_exp(8'(i));
    check("fill16_count", 32'(count), 32'd15);
    check("fill16_full", 32'(full), 32'd0);
    check("fill16_tx_data", 32'(tx_data), 32'h00);
    check("fill16_state", 32'(dbg_state), 32'd2);
    wr_exp(8'h10);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count16", 32'(count), 32'd16);
    wr(8'h11);
    check("drop_count", 32'(count), 32'd16);
    check("drop_overflow", 32'(overflow), 32'(EXP_OVF));
    busy_force = 1'b0;
    @(negedge clk);
    check("full_idle_state", 32'(dbg_state), 32'd0);
    wr(8'h12);
    check("full_wr_pop_count", 32'(count), 32'd15);
    check("full_wr_pop_data", 32'(tx_data), 32'h01);
    check("full_wr_pop_state", 32'(dbg_state), 32'd1);
    auto_busy = 1'b1;
    wait_idle(2000, "drain_after_full");

    // three bytes, busy pulsed per byte
    rise_before = rise_cnt;
    wr_exp(8'h01);
    wr_exp(8'h02);
    wr_exp(8'h03);
    wait_idle(500, "idle_after_three");
    check("three_send_pulses", 32'(rise_cnt - rise_before), 32'd3);

    // flush with five queued and one in flight
    auto_busy = 1'b0; busy_force = 1'b1;
    rise_before = rise_cnt;
    wr_exp(8'h20);
    for (int i = 1; i < 6; i++) wr(8'(8'h20 + i));
    check("pre_flush_count", 32'(count), 32'd5);
    check("pre_flush_state", 32'(dbg_state), 32'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_state_kept", 32'(dbg_state), 32'd2);
    check("flush_tx_data_kept", 32'(tx_data), 32'h20);
    busy_force = 1'b0;
    @(negedge clk);
    wait_idle(50, "idle_after_flush");
    repeat (5) @(negedge clk);
    check("flush_no_more_send", 32'(rise_cnt - rise_before), 32'd1);

    // reset while in S_SEND with four queued
    wr_exp(8'h30);
    for (int i = 1; i < 5; i++) wr(8'(8'h30 + i));
    check("pre_rst_count", 32'(count), 32'd4);
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_send", 32'(tx_send), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("after_rst_idle_send", 32'(tx_send), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter ADDR_WIDTH, default 4, log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_en  input  1  enqueue request, sampled each clk edge.
REQ-007 flush  input  1  synchronous queue clear.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 empty  output  1  high when count == 0.
REQ-010 count  output  ADDR_WIDTH+1  number of stored bytes.
REQ-011 overflow  output  1  sticky flag: a write was dropped.
REQ-012 tx_data  output  8  byte presented to the downstream uart_transmitter data input.
REQ-013 tx_send  output  1  send request to uart_transmitter.
REQ-014 tx_busy  input  1  busy from uart_transmitter.

Function
REQ-015 Storage SHALL be a circular buffer with ADDR_WIDTH-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-016 When wr_en=1 and full=0 at a clk edge, wr_data SHALL be written at the write pointer, the pointer SHALL advance and count SHALL increment.
REQ-017 When wr_en=1 and full=1, the write SHALL be dropped, even if a pop occurs in the same cycle.
REQ-018 Control FSM states: S_IDLE, S_SEND, S_BUSY.
REQ-019 S_IDLE with empty=0: the FSM SHALL load tx_data from the head entry, advance the read pointer, decrement count and go to S_SEND, all on one edge.
REQ-020 S_IDLE with empty=1: the FSM SHALL stay in S_IDLE.
REQ-021 S_SEND: tx_send SHALL be 1; on tx_busy=1 the FSM SHALL go to S_BUSY, otherwise it SHALL remain in S_SEND indefinitely.
REQ-022 S_BUSY: tx_send SHALL be 0; on tx_busy=0 the FSM SHALL go to S_IDLE.
REQ-023 tx_send SHALL be registered, high exactly while the state is S_SEND.
REQ-024 tx_data SHALL hold its value from the pop until the next pop.
REQ-025 Simultaneous write (not full) and pop: count SHALL be unchanged and both pointers SHALL advance.
REQ-026 Minimum latency from a write into an empty idle queue to tx_send=1 SHALL be 2 clk edges: write, then pop.
REQ-027 flush=1 SHALL zero both pointers and count; any write or pop in the same cycle SHALL be ignored.
REQ-028 flush SHALL NOT alter FSM state, tx_data or tx_send; an in-flight byte SHALL complete.
REQ-029 full, empty and count SHALL be derived from registered count only, with no combinational path from wr_en.

Reset
REQ-030 reset=1 SHALL immediately force pointers=0, count=0, FSM=S_IDLE, tx_send=0, tx_data=8'h00 and overflow=0.
REQ-031 Reset mid-transmission SHALL abandon the byte; the FSM SHALL NOT wait for tx_busy to fall.
REQ-032 Storage array contents need not be reset.
REQ-033 After reset deasserts: empty=1, full=0, count=0.

Configuration
REQ-034 Macro UART_TX_QUEUE_OVERFLOW_EN:
- Defined: overflow SHALL be set on the edge where a write is dropped per REQ-017.
- Defined: overflow SHALL be cleared only by reset or by flush=1.
- Undefined: overflow SHALL be tied to 0 and no overflow register SHALL be synthesized.
- The port list SHALL be identical in both builds.

Verification
REQ-035 Reset, write 8'hA5, tx_busy model rises 3 cycles after tx_send and stays high 20 cycles:
- tx_data=8'hA5 and tx_send=1 on the 2nd edge after the write.
- tx_send falls the edge after tx_busy=1.
- empty=1 after the pop.
REQ-036 Write 16 bytes 8'h00..8'h0F with tx_busy held 1:
- tx_data=8'h00, count=15, full=0.
- Further writes until full=1: next write dropped, overflow=1 (macro defined) or 0 (undefined).
REQ-037 Write 3 bytes while tx_busy is pulsed per byte:
- Output order 8'h01, 8'h02, 8'h03.
- Exactly one tx_send assertion per byte.
- Pointer wrap exercised after 20 total bytes.
REQ-038 Queue holding 5 bytes, byte in flight in S_BUSY, assert flush:
- count=0 and overflow=0 next edge.
- In-flight byte completes and the FSM returns to S_IDLE with no further tx_send.
REQ-039 Assert reset while in S_SEND with count=4: tx_send=0, count=0, empty=1 immediately, without waiting for a clk edge.
REQ-040 Queue full, simultaneous write and pop in S_IDLE:
- The write is dropped.
- count becomes DEPTH-1.
